// File: rtl/wb_burst_mem_slave.sv
// Wishbone B3 byte-addressed RAM slave: classic cycles plus registered-feedback
// bursts (constant / incrementing, linear and wrap4/8/16), wait states and error on out-of-range.
module wb_burst_mem_slave #(
  parameter int aw          = 32,
  parameter int dw          = 32,
  parameter int MEM_BYTES   = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_n_i,
  input  logic [aw-1:0]   wb_adr_i,
  input  logic [dw-1:0]   wb_dat_i,
  input  logic [dw/8-1:0] wb_sel_i,
  input  logic            wb_we_i,
  input  logic            wb_cyc_i,
  input  logic            wb_stb_i,
  input  logic [2:0]      wb_cti_i,
  input  logic [1:0]      wb_bte_i,
  output logic [dw-1:0]   wb_dat_o,
  output logic            wb_ack_o,
  output logic            wb_err_o,
  output logic            wb_rty_o
);
  localparam int BYTES   = dw / 8;
  localparam int ADR_LSB = $clog2(BYTES);
  localparam int DEPTH   = MEM_BYTES / BYTES;
  localparam int IW      = $clog2(DEPTH);
  localparam logic [aw-1:0] BEAT   = aw'(BYTES);
  localparam logic [aw-1:0] LIMIT  = aw'(MEM_BYTES);
  localparam logic [aw-1:0] MASK4  = aw'(4 * BYTES - 1);
  localparam logic [aw-1:0] MASK8  = aw'(8 * BYTES - 1);
  localparam logic [aw-1:0] MASK16 = aw'(16 * BYTES - 1);
  localparam logic [3:0]    WS_LOAD = 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {IDLE, WAIT, ACK, BURST} state_t;

  state_t        state_reg, state_next;
  logic [3:0]    wait_reg, wait_next;
  logic          ack_reg, ack_next;
  logic          err_reg, err_next;
  logic [aw-1:0] pred_reg, pred_next;

  logic          req, hit, respond, rd_en, wr_en;
  logic [aw-1:0] rd_adr;
  logic [IW-1:0] rd_idx, wr_idx;

  function automatic logic is_burst(input logic [2:0] cti);
    return (cti == 3'b001) || (cti == 3'b010);
  endfunction

  function automatic logic [aw-1:0] next_adr(input logic [aw-1:0] adr,
                                             input logic [2:0] cti,
                                             input logic [1:0] bte);
    logic [aw-1:0] inc;
    logic [aw-1:0] mask;
    inc = adr + BEAT;
    case (bte)
      2'b01:   mask = MASK4;
      2'b10:   mask = MASK8;
      2'b11:   mask = MASK16;
      default: mask = '0;
    endcase
    if (cti == 3'b001)
      return adr;
    else if (bte == 2'b00)
      return inc;
    else
      return (adr & ~mask) | (inc & mask);
  endfunction

  assign req = wb_cyc_i & wb_stb_i;
  // A registered response only terminates the beat it was issued for.
  assign hit = req && (wb_adr_i == pred_reg);

  assign wb_ack_o = ack_reg & hit;
  assign wb_err_o = err_reg & hit;
  assign wb_rty_o = 1'b0;

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_reg <= IDLE;
      wait_reg  <= '0;
      ack_reg   <= 1'b0;
      err_reg   <= 1'b0;
      pred_reg  <= '0;
    end else begin
      state_reg <= state_next;
      wait_reg  <= wait_next;
      ack_reg   <= ack_next;
      err_reg   <= err_next;
      pred_reg  <= pred_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    wait_next  = wait_reg;
    pred_next  = pred_reg;
    ack_next   = 1'b0;
    err_next   = 1'b0;
    respond    = 1'b0;
    rd_adr     = wb_adr_i;
    case (state_reg)
      IDLE: begin
        // While a response is on the bus the master has not yet released this beat.
        if (req && !ack_reg && !err_reg) begin
          pred_next = wb_adr_i;
          if (wb_adr_i >= LIMIT) begin
            state_next = ACK;
          end else if (WAIT_STATES > 0) begin
            state_next = WAIT;
            wait_next  = WS_LOAD;
          end else begin
            state_next = is_burst(wb_cti_i) ? BURST : ACK;
          end
        end
      end
      WAIT: begin
        if (!req)
          state_next = IDLE;
        else if (wait_reg == 4'd0)
          state_next = is_burst(wb_cti_i) ? BURST : ACK;
        else
          wait_next = wait_reg - 4'd1;
      end
      ACK: begin
        state_next = IDLE;
        respond    = req;
      end
      BURST: begin
        if ((ack_reg || err_reg) && hit) begin
          if (err_reg || !is_burst(wb_cti_i)) begin
            state_next = IDLE;
          end else begin
            respond = 1'b1;
            rd_adr  = next_adr(wb_adr_i, wb_cti_i, wb_bte_i);
          end
        end else if (req && (wb_adr_i != pred_reg)) begin
          state_next = IDLE;
        end else if (req) begin
          respond = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    if (respond) begin
      pred_next = rd_adr;
      if (rd_adr >= LIMIT)
        err_next = 1'b1;
      else
        ack_next = 1'b1;
    end

    if (!wb_cyc_i) begin
      state_next = IDLE;
      ack_next   = 1'b0;
      err_next   = 1'b0;
    end
  end

  assign rd_en  = ack_next;
  assign rd_idx = rd_adr[ADR_LSB +: IW];
  assign wr_en  = wb_ack_o & wb_we_i;
  assign wr_idx = wb_adr_i[ADR_LSB +: IW];

  for (genvar gi = 0; gi < BYTES; gi++) begin : g_lane
    logic [7:0] mem [DEPTH];
    logic [7:0] q_reg;

    always_ff @(posedge wb_clk_i) begin
      if (wr_en && wb_sel_i[gi])
        mem[wr_idx] <= wb_dat_i[8*gi +: 8];
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i)
        q_reg <= '0;
      else if (rd_en)
        q_reg <= mem[rd_idx];
    end

    assign wb_dat_o[8*gi +: 8] = q_reg;
  end

endmodule

// File: tb/tb_wb_burst_mem_slave.sv
// Self-checking bench: two slaves (0 and 3 wait states) on a shared master bus,
// directed spec scenarios plus random classic/burst traffic against a byte-array model.
module tb_wb_burst_mem_slave;
  localparam int MEMB = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] adr = '0;
  logic [31:0] dat_w = '0;
  logic [3:0]  sel = '0;
  logic        we = 1'b0, cyc = 1'b0, stb = 1'b0;
  logic [2:0]  cti = '0;
  logic [1:0]  bte = '0;
  int          dut_sel = 0;

  logic        cyc_a, cyc_b;
  logic [31:0] dat_a, dat_b, rdat;
  logic        ack_a, ack_b, err_a, err_b, rty_a, rty_b, ack, err;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] model [2][MEMB];

  always #5 clk = ~clk;

  assign cyc_a = cyc && (dut_sel == 0);
  assign cyc_b = cyc && (dut_sel != 0);
  assign rdat  = (dut_sel != 0) ? dat_b : dat_a;
  assign ack   = (dut_sel != 0) ? ack_b : ack_a;
  assign err   = (dut_sel != 0) ? err_b : err_a;

  wb_burst_mem_slave #(.aw(32), .dw(32), .MEM_BYTES(MEMB), .WAIT_STATES(0)) dut_a (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n), .wb_adr_i(adr), .wb_dat_i(dat_w), .wb_sel_i(sel),
    .wb_we_i(we), .wb_cyc_i(cyc_a), .wb_stb_i(stb), .wb_cti_i(cti), .wb_bte_i(bte),
    .wb_dat_o(dat_a), .wb_ack_o(ack_a), .wb_err_o(err_a), .wb_rty_o(rty_a));

  wb_burst_mem_slave #(.aw(32), .dw(32), .MEM_BYTES(MEMB), .WAIT_STATES(3)) dut_b (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n), .wb_adr_i(adr), .wb_dat_i(dat_w), .wb_sel_i(sel),
    .wb_we_i(we), .wb_cyc_i(cyc_b), .wb_stb_i(stb), .wb_cti_i(cti), .wb_bte_i(bte),
    .wb_dat_o(dat_b), .wb_ack_o(ack_b), .wb_err_o(err_b), .wb_rty_o(rty_b));

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int ws_of(input int d);
    return (d != 0) ? 3 : 0;
  endfunction

  // Negedges without a response after a request is first driven: the request is
  // sampled at the next edge k and the response is visible after edge k+1+WS.
  function automatic int exp_lead(input int d);
    return ws_of(d) + 2;
  endfunction

  function automatic logic [31:0] model_word(input int d, input int a);
    return {model[d][a+3], model[d][a+2], model[d][a+1], model[d][a]};
  endfunction

  task automatic model_write(input int d, input int a, input logic [3:0] s, input logic [31:0] v);
    for (int i = 0; i < 4; i++)
      if (s[i]) model[d][a+i] = v[8*i +: 8];
  endtask

  // Wishbone address progression in plain arithmetic: ctype 1 = constant, 2 = incrementing.
  function automatic int model_next(input int a, input int ctype, input int b);
    int span;
    if (ctype == 1) return a;
    if (b == 0) return a + 4;
    span = (b == 1) ? 16 : (b == 2) ? 32 : 64;
    return (a / span) * span + ((a % span) + 4) % span;
  endfunction

  task automatic classic(input int d, input bit w, input int a, input logic [3:0] s,
                         input logic [31:0] wd, input bit hold,
                         output logic [31:0] rd, output bit got_ack, output bit got_err,
                         output int lat);
    dut_sel = d; adr = 32'(a); we = w; sel = s; dat_w = wd; cti = 3'b000; bte = 2'b00;
    cyc = 1'b1; stb = 1'b1;
    lat = 0; got_ack = 1'b0; got_err = 1'b0; rd = '0;
    while (!(got_ack || got_err) && lat < 64) begin
      @(negedge clk);
      if (ack || err) begin
        got_ack = ack; got_err = err; rd = rdat;
        check_val("ack_err_excl", {31'b0, ack & err}, 32'd0);
      end else begin
        lat++;
      end
    end
    if (!(got_ack || got_err)) check_val("classic_timeout", 32'd1, 32'd0);
    if (got_ack && w) model_write(d, a, s, wd);
    @(posedge clk); #1;
    if (hold) begin
      @(negedge clk);
      check_val("no_back_to_back", {30'b0, ack, err}, 32'd0);
      @(posedge clk); #1;
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic burst(input int d, input bit w, input int start, input int n,
                       input int ctype, input int b, input int stall_at, input int stall_len,
                       output int beats, output int gaps, output int lead, output int err_beat);
    int a, budget, stall_left;
    bit started;
    dut_sel = d; we = w; sel = 4'hF; bte = 2'(b);
    a = start; beats = 0; gaps = 0; lead = 0; err_beat = -1;
    budget = 0; stall_left = 0; started = 1'b0;
    adr = 32'(a); dat_w = $urandom; cti = (n == 1) ? 3'b111 : 3'(ctype);
    cyc = 1'b1; stb = 1'b1;
    while (beats < n && err_beat < 0 && budget < 200) begin
      @(negedge clk);
      budget++;
      if (err) begin
        err_beat = beats;
        check_val("err_excl_ack", {31'b0, ack}, 32'd0);
      end else if (ack) begin
        if (w) model_write(d, a, 4'hF, dat_w);
        else check_val("burst_rdata", rdat, model_word(d, a));
        started = 1'b1;
        beats++;
        a = model_next(a, ctype, b);
        @(posedge clk); #1;
        adr = 32'(a); dat_w = $urandom;
        cti = (beats == n - 1) ? 3'b111 : 3'(ctype);
        if (beats == stall_at && stall_len > 0) begin
          stb = 1'b0;
          stall_left = stall_len;
        end
      end else begin
        if (started) gaps++; else lead++;
        @(posedge clk); #1;
        if (stall_left > 0) begin
          stall_left--;
          if (stall_left == 0) stb = 1'b1;
        end
      end
    end
    if (beats < n && err_beat < 0) check_val("burst_timeout", 32'(beats), 32'(n));
    cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = 3'b000;
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete (got timeout, required finish)");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    bit ga, ge;
    int lat, beats, gaps, lead, eb, n_ack;

    repeat (3) @(posedge clk);
    #1;
    check_val("rst_ack_a", {29'b0, ack_a, err_a, rty_a}, 32'd0);
    check_val("rst_ack_b", {29'b0, ack_b, err_b, rty_b}, 32'd0);
    check_val("rst_dat_a", dat_a, 32'd0);
    check_val("rst_dat_b", dat_b, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Fill both RAMs with 16-beat linear write bursts so every byte is known.
    for (int d = 0; d < 2; d++)
      for (int blk = 0; blk < MEMB / 64; blk++) begin
        burst(d, 1'b1, blk * 64, 16, 2, 0, -1, 0, beats, gaps, lead, eb);
        check_val("fill_beats", 32'(beats), 32'd16);
        check_val("fill_gaps", 32'(gaps), 32'd0);
        check_val("fill_lead", 32'(lead), 32'(exp_lead(d)));
      end

    classic(0, 1'b1, 'h10, 4'hF, 32'hDEADBEEF, 1'b0, rd, ga, ge, lat);
    check_val("wr_ack", {31'b0, ga}, 32'd1);
    classic(0, 1'b0, 'h10, 4'hF, 32'h0, 1'b0, rd, ga, ge, lat);
    check_val("rd_deadbeef", rd, 32'hDEADBEEF);
    check_val("rd_lat_ws0", 32'(lat), 32'(exp_lead(0)));
    classic(0, 1'b1, 'h10, 4'b0010, 32'h0000AA00, 1'b0, rd, ga, ge, lat);
    classic(0, 1'b0, 'h10, 4'hF, 32'h0, 1'b1, rd, ga, ge, lat);
    check_val("rd_byte_lane", rd, 32'hDEADAAEF);

    burst(0, 1'b1, 'h40, 8, 2, 0, -1, 0, beats, gaps, lead, eb);
    check_val("incr8_wr_beats", 32'(beats), 32'd8);
    check_val("incr8_wr_gaps", 32'(gaps), 32'd0);
    burst(0, 1'b0, 'h40, 8, 2, 0, -1, 0, beats, gaps, lead, eb);
    check_val("incr8_rd_beats", 32'(beats), 32'd8);
    check_val("incr8_rd_gaps", 32'(gaps), 32'd0);

    burst(0, 1'b0, 'h38, 4, 2, 1, -1, 0, beats, gaps, lead, eb);
    check_val("wrap4_beats", 32'(beats), 32'd4);
    check_val("wrap4_gaps", 32'(gaps), 32'd0);
    burst(0, 1'b0, 'h74, 8, 2, 2, -1, 0, beats, gaps, lead, eb);
    check_val("wrap8_gaps", 32'(gaps), 32'd0);
    burst(1, 1'b0, 'hE8, 16, 2, 3, -1, 0, beats, gaps, lead, eb);
    check_val("wrap16_gaps", 32'(gaps), 32'd0);

    classic(1, 1'b0, 'h10, 4'hF, 32'h0, 1'b1, rd, ga, ge, lat);
    check_val("rd_lat_ws3", 32'(lat), 32'd5);
    check_val("rd_ws3_data", rd, model_word(1, 'h10));
    burst(1, 1'b0, 'h80, 8, 2, 0, 3, 2, beats, gaps, lead, eb);
    check_val("stall_beats", 32'(beats), 32'd8);
    check_val("stall_gaps", 32'(gaps), 32'd3);
    check_val("stall_lead", 32'(lead), 32'd5);

    classic(0, 1'b0, 'h400, 4'hF, 32'h0, 1'b1, rd, ga, ge, lat);
    check_val("oor_err", {30'b0, ga, ge}, 32'd1);
    check_val("oor_lat", 32'(lat), 32'(exp_lead(0)));
    classic(1, 1'b1, 'h7FC, 4'hF, 32'h12345678, 1'b0, rd, ga, ge, lat);
    check_val("oor_wr_err", {30'b0, ga, ge}, 32'd1);
    burst(0, 1'b0, 'h3F8, 4, 2, 0, -1, 0, beats, gaps, lead, eb);
    check_val("cross_err_beat", 32'(eb), 32'd2);

    // Reset in the middle of an incrementing read burst.
    dut_sel = 0; we = 1'b0; sel = 4'hF; cti = 3'b010; bte = 2'b00; adr = 32'h100;
    cyc = 1'b1; stb = 1'b1; n_ack = 0;
    for (int c = 0; c < 20 && n_ack < 2; c++) begin
      @(negedge clk);
      if (ack) begin
        n_ack++;
        @(posedge clk); #1;
        adr = adr + 32'd4;
      end else begin
        @(posedge clk); #1;
      end
    end
    @(negedge clk);
    check_val("pre_rst_ack", {31'b0, ack}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check_val("mid_rst_resp", {30'b0, ack, err}, 32'd0);
    check_val("mid_rst_dat", rdat, 32'd0);
    cyc = 1'b0; stb = 1'b0; cti = 3'b000;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    classic(0, 1'b0, 'h104, 4'hF, 32'h0, 1'b0, rd, ga, ge, lat);
    check_val("post_rst_rd", rd, model_word(0, 'h104));
    check_val("post_rst_lat", 32'(lat), 32'(exp_lead(0)));

    for (int it = 0; it < 60; it++) begin
      int d, op, n, ct, b, st, sl, a;
      d  = int'($urandom_range(0, 1));
      op = int'($urandom_range(0, 4));
      case (op)
        0: begin
          a = int'($urandom_range(0, MEMB / 4 - 1)) * 4;
          classic(d, 1'b1, a, 4'($urandom_range(0, 15)), $urandom, 1'b0, rd, ga, ge, lat);
          check_val("rnd_wr_ack", {31'b0, ga}, 32'd1);
        end
        1: begin
          a = int'($urandom_range(0, MEMB / 4 - 1)) * 4;
          classic(d, 1'b0, a, 4'hF, 32'h0, 1'($urandom_range(0, 1)), rd, ga, ge, lat);
          check_val("rnd_rd_data", rd, model_word(d, a));
          check_val("rnd_rd_lat", 32'(lat), 32'(exp_lead(d)));
        end
        2: begin
          a = MEMB + int'($urandom_range(0, 255)) * 4;
          classic(d, 1'b0, a, 4'hF, 32'h0, 1'b0, rd, ga, ge, lat);
          check_val("rnd_oor", {30'b0, ga, ge}, 32'd1);
        end
        default: begin
          n  = int'($urandom_range(1, 10));
          ct = int'($urandom_range(1, 2));
          b  = int'($urandom_range(0, 3));
          a  = int'($urandom_range(0, MEMB / 4 - 12)) * 4;
          st = (n > 1 && $urandom_range(0, 1) == 1) ? int'($urandom_range(1, n - 1)) : -1;
          sl = (st > 0) ? int'($urandom_range(1, 3)) : 0;
          burst(d, 1'(op == 3), a, n, ct, b, st, sl, beats, gaps, lead, eb);
          check_val("rnd_burst_beats", 32'(beats), 32'(n));
          check_val("rnd_burst_gaps", 32'(gaps), 32'(sl > 0 ? sl + 1 : 0));
          check_val("rnd_burst_lead", 32'(lead), 32'(exp_lead(d)));
        end
      endcase
    end

    check_val("rty_tied_low", {30'b0, rty_a, rty_b}, 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
